// File: rtl/ram_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_writer_pkg
// Description : Shared types and default widths for the RAM stream writer.
//               Holds the burst FSM state encoding and the default word and
//               address widths used by ram_stream_writer and dp_sync_ram.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_writer_pkg;

    localparam int c_DEF_DATA_WIDTH = 8;
    localparam int c_DEF_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dp_sync_ram.sv
`default_nettype none
// ============================================================================
// Module      : dp_sync_ram
// Description : Simple dual-port synchronous RAM, one write port and one
//               registered read port (1-cycle latency).
//               Ports:
//                 clk      - rising-edge clock
//                 rst      - asynchronous active-high reset (read register only)
//                 wr_en    - write enable
//                 wr_addr  - write address
//                 wr_data  - write data
//                 rd_addr  - read address
//                 rd_data  - registered read data
//               A read and write to the same address in one cycle returns the
//               old contents; the new word is seen on the following read.
//               The array itself is never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_sync_ram
    import ram_writer_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Array kept reset-free so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read samples the array before this edge's write lands, which is what
    // gives the read-old-on-collision behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/ram_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : ram_stream_writer
// Description : Burst writer for a synchronous lookup memory. A start pulse
//               captures a base address and a length, then valid/ready words
//               are written to auto-incrementing (wrapping) addresses.
//               Ports:
//                 clk, rst   - clock, asynchronous active-high reset
//                 start      - burst request, sampled in IDLE only
//                 base_addr  - first write address
//                 length     - words in burst (0 allowed)
//                 in_data    - stream data
//                 in_valid   - stream valid
//                 in_ready   - writer accepts a word this cycle
//                 busy       - burst in progress (LOAD or DONE)
//                 done       - one-cycle completion pulse
//                 wr_count   - words written in current/last burst
//                 rd_addr    - read address
//                 Dout       - registered read data, 1-cycle latency
// Revision    : 1.0 - initial release
// ============================================================================
module ram_stream_writer
    import ram_writer_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] Dout
);

    localparam logic [ADDR_WIDTH:0] c_ONE = (ADDR_WIDTH+1)'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [ADDR_WIDTH:0]   r_wr_count;
    logic                  w_accept;
    logic                  w_transfer;

    assign w_accept   = (r_state == IDLE) && start;
    // Reset forces IDLE asynchronously, so no write can slip through on a
    // reset edge.
    assign w_transfer = (r_state == LOAD) && in_valid;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (length == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (r_remaining == c_ONE)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Address wraps naturally at ADDR_WIDTH bits, so bursts longer than the
    // depth overwrite earlier words of the same burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_addr   <= '0;
            r_remaining <= '0;
            r_wr_count  <= '0;
        end else if (w_accept) begin
            r_wr_addr   <= base_addr;
            r_remaining <= length;
            r_wr_count  <= '0;
        end else if (w_transfer) begin
            r_wr_addr   <= r_wr_addr + 1'b1;
            r_remaining <= r_remaining - c_ONE;
            r_wr_count  <= r_wr_count + c_ONE;
        end
    end

    assign wr_count = r_wr_count;

    dp_sync_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_transfer),
        .wr_addr (r_wr_addr),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (Dout)
    );

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_stream_writer
// Description : Self-checking bench for ram_stream_writer. A table of
//               single-cycle vectors covers the basic and zero-length bursts;
//               hand-written sequences cover wrap/backpressure, ignored start,
//               read-during-write collision and reset mid-burst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_stream_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] length;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [4:0] wr_count;
    logic [3:0] rd_addr;
    logic [7:0] Dout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_stream_writer #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count),
        .rd_addr   (rd_addr),
        .Dout      (Dout)
    );

    typedef struct {
        string      nm;
        logic       s;
        logic [3:0] b;
        logic [4:0] l;
        logic       v;
        logic [7:0] d;
        logic [3:0] r;
        logic       e_rdy;
        logic       e_busy;
        logic       e_done;
        logic [4:0] e_wc;
        logic       cd;
        logic [7:0] e_dout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic s, input logic [3:0] b,
                                input logic [4:0] l, input logic v, input logic [7:0] d,
                                input logic [3:0] r, input logic e_rdy, input logic e_busy,
                                input logic e_done, input logic [4:0] e_wc, input logic cd,
                                input logic [7:0] e_dout);
        vec_t t;
        t.nm = nm; t.s = s; t.b = b; t.l = l; t.v = v; t.d = d; t.r = r;
        t.e_rdy = e_rdy; t.e_busy = e_busy; t.e_done = e_done; t.e_wc = e_wc;
        t.cd = cd; t.e_dout = e_dout;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] b, input logic [4:0] l,
                         input logic v, input logic [7:0] d, input logic [3:0] r);
        start = s; base_addr = b; length = l; in_valid = v; in_data = d; rd_addr = r;
    endtask

    task automatic read_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        drive(0, 0, 0, 0, 8'h00, a);
        tick();
        chk(name, Dout, exp);
    endtask

    // Global guard: the sequences below are fixed-length, this only catches a
    // simulator-level stall.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] wrap_addr [4];
        int k;
        logic vv;

        wrap_addr[0] = 4'd14; wrap_addr[1] = 4'd15; wrap_addr[2] = 4'd0; wrap_addr[3] = 4'd1;

        // ---------------- reset then idle ----------------
        rst = 1'b1;
        drive(0, 0, 0, 0, 8'h00, 0);
        tick(); tick();
        chk("rst_dout", Dout, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdy", in_ready, 1'b0);
        chk("rst_wc", wr_count, 5'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_busy", busy, 1'b0);
            chk("idle_rdy", in_ready, 1'b0);
        end

        // ---------------- table: basic burst and zero length ----------------
        //            name        s  b  l  v  d      r   rdy busy done wc cd dout
        tbl.push_back(mk("bb_start", 1, 2, 3, 0, 8'h00, 0, 1, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk("bb_w0",    0, 0, 0, 1, 8'hA1, 0, 1, 1, 0, 1, 0, 8'h00));
        tbl.push_back(mk("bb_w1",    0, 0, 0, 1, 8'hB2, 0, 1, 1, 0, 2, 0, 8'h00));
        tbl.push_back(mk("bb_w2",    0, 0, 0, 1, 8'hC3, 0, 0, 1, 1, 3, 0, 8'h00));
        // start during DONE is dropped: back to IDLE, count held
        tbl.push_back(mk("bb_rd2",   1, 7, 1, 0, 8'h00, 2, 0, 0, 0, 3, 1, 8'hA1));
        tbl.push_back(mk("bb_rd3",   0, 0, 0, 0, 8'h00, 3, 0, 0, 0, 3, 1, 8'hB2));
        tbl.push_back(mk("bb_rd4",   0, 0, 0, 0, 8'h00, 4, 0, 0, 0, 3, 1, 8'hC3));
        tbl.push_back(mk("z_start",  1, 2, 0, 1, 8'hFF, 2, 0, 1, 1, 0, 1, 8'hA1));
        tbl.push_back(mk("z_back",   0, 0, 0, 1, 8'hFF, 2, 0, 0, 0, 0, 1, 8'hA1));
        tbl.push_back(mk("z_hold",   0, 0, 0, 1, 8'hFF, 2, 0, 0, 0, 0, 1, 8'hA1));

        foreach (tbl[i]) begin
            drive(tbl[i].s, tbl[i].b, tbl[i].l, tbl[i].v, tbl[i].d, tbl[i].r);
            tick();
            chk({tbl[i].nm, "_rdy"},  in_ready, tbl[i].e_rdy);
            chk({tbl[i].nm, "_busy"}, busy,     tbl[i].e_busy);
            chk({tbl[i].nm, "_done"}, done,     tbl[i].e_done);
            chk({tbl[i].nm, "_wc"},   wr_count, tbl[i].e_wc);
            if (tbl[i].cd) chk({tbl[i].nm, "_dout"}, Dout, tbl[i].e_dout);
        end

        // ---------------- wrap and backpressure ----------------
        drive(1, 14, 4, 0, 8'h00, 0);
        tick();
        chk("wr_start_busy", busy, 1'b1);
        k = 0;
        for (int i = 0; i < 7; i++) begin
            vv = (i % 2 == 0);
            drive(0, 0, 0, vv, vv ? 8'(8'h50 + k) : 8'hEE, 0);
            tick();
            if (vv) k++;
            chk("wr_wc", wr_count, 5'(k));
            chk("wr_done", done, (k == 4) && vv);
        end
        drive(0, 0, 0, 0, 8'h00, 0);
        tick();
        chk("wr_idle_busy", busy, 1'b0);
        for (int j = 0; j < 4; j++) read_chk("wr_rd", wrap_addr[j], 8'(8'h50 + j));

        // ---------------- start ignored during LOAD ----------------
        drive(1, 8, 5, 0, 8'h00, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(i == 2, 0, 1, 1, 8'(8'h60 + i), 0);
            tick();
            chk("ig_wc", wr_count, 5'(i + 1));
            chk("ig_done", done, i == 4);
        end
        drive(0, 0, 0, 0, 8'h00, 0);
        tick();
        chk("ig_busy1", busy, 1'b0);
        tick();
        chk("ig_busy2", busy, 1'b0);
        chk("ig_wc_hold", wr_count, 5'd5);
        for (int j = 0; j < 5; j++) read_chk("ig_rd", 4'(8 + j), 8'(8'h60 + j));
        read_chk("ig_rd0", 4'd0, 8'h52);

        // ---------------- read-during-write collision ----------------
        drive(1, 5, 1, 0, 8'h00, 0);
        tick();
        drive(0, 0, 0, 1, 8'h11, 0);
        tick();
        drive(0, 0, 0, 0, 8'h00, 5);
        tick();
        drive(1, 5, 1, 0, 8'h00, 5);
        tick();
        chk("coll_pre", Dout, 8'h11);
        drive(0, 0, 0, 1, 8'h22, 5);
        tick();
        chk("coll_old", Dout, 8'h11);
        drive(0, 0, 0, 0, 8'h00, 5);
        tick();
        chk("coll_new", Dout, 8'h22);
        tick();

        // ---------------- reset mid-burst ----------------
        drive(1, 0, 6, 0, 8'h00, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 8'(8'h31 + i), 0);
            tick();
        end
        drive(0, 0, 0, 1, 8'h99, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_rdy", in_ready, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_done", done, 1'b0);
        chk("mr_dout", Dout, 8'h00);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_nodone", done, 1'b0);
            chk("mr_idle", busy, 1'b0);
        end
        for (int j = 0; j < 3; j++) read_chk("mr_keep", 4'(j), 8'(8'h31 + j));
        read_chk("mr_nowr3", 4'd3, 8'hB2);
        drive(1, 0, 2, 0, 8'h00, 0);
        tick();
        chk("mr2_busy", busy, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 1, 8'(8'h41 + i), 0);
            tick();
            chk("mr2_done", done, i == 1);
            chk("mr2_wc", wr_count, 5'(i + 1));
        end
        drive(0, 0, 0, 0, 8'h00, 0);
        tick();
        read_chk("mr2_rd0", 4'd0, 8'h41);
        read_chk("mr2_rd1", 4'd1, 8'h42);
        read_chk("mr2_rd2", 4'd2, 8'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
